mac_sequencer: RTL and testbench

- Downstream controller for the sequential `shift_add_multiplier`.
- Accepts a stream of operand pairs over a valid/ready handshake and issues one multiply at a time via `start`/`done`.
- Accumulates the N_TERMS products and presents the dot-product sum on a valid/ready output.
- Sits between the operand source and result consumers; the multiplier instance is external and connects through the `mul_*` ports.

---
 rtl/mac_sequencer.sv | 126 ++++++++++++
 tb/tb_mac_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_sequencer.sv
// Sequences operand pairs through an external multiplier, one multiply at a time,
// and accumulates N_TERMS products into a dot-product result.
module mac_sequencer #(
   parameter int W       = 4,
   parameter int N_TERMS = 4,
   parameter int ACC_W   = 10,
   parameter int TIMEOUT = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [W-1:0]       in_a,
   input  logic [W-1:0]       in_b,
   output logic               mul_start,
   output logic [W-1:0]       mul_a,
   output logic [W-1:0]       mul_b,
   input  logic [2*W-1:0]     mul_p,
   input  logic               mul_done,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [ACC_W-1:0]   out_sum,
   output logic               err
);

   localparam int CW = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {IDLE, START, WAIT, OUT} state_t;

   state_t             state;
   state_t             state_d;
   logic [ACC_W-1:0]   acc;
   logic [ACC_W-1:0]   acc_sum;
   logic [CW-1:0]      count;
   logic [TW-1:0]      timer;
   logic               accept;
   logic               accum;
   logic               abort;
   logic               drain;
   logic               last;

   assign acc_sum = acc + ACC_W'(mul_p);
   assign last    = (count == CW'(N_TERMS - 1));

   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_d;
   end

   always_comb begin
      state_d   = state;
      in_ready  = 1'b0;
      mul_start = 1'b0;
      out_valid = 1'b0;
      accept    = 1'b0;
      accum     = 1'b0;
      abort     = 1'b0;
      drain     = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               accept  = 1'b1;
               state_d = START;
            end
         end
         START: begin
            mul_start = 1'b1;
            state_d   = WAIT;
         end
         WAIT: begin
            // a completion arriving on the final timer cycle still counts
            if (mul_done) begin
               accum   = 1'b1;
               state_d = last ? OUT : IDLE;
            end else if (timer == TW'(TIMEOUT - 1)) begin
               abort   = 1'b1;
               state_d = IDLE;
            end
         end
         OUT: begin
            out_valid = 1'b1;
            if (out_ready) begin
               drain   = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         acc     <= '0;
         count   <= '0;
         timer   <= '0;
         mul_a   <= '0;
         mul_b   <= '0;
         out_sum <= '0;
         err     <= 1'b0;
      end else begin
         if (accept) begin
            mul_a <= in_a;
            mul_b <= in_b;
         end
         if (state == START)     timer <= '0;
         else if (state == WAIT) timer <= timer + TW'(1);
         if (accum) begin
            acc   <= acc_sum;
            count <= count + CW'(1);
            if (last) out_sum <= acc_sum;
         end
         if (abort) begin
            acc   <= '0;
            count <= '0;
            err   <= 1'b1;
         end
         if (drain) begin
            acc   <= '0;
            count <= '0;
         end
      end
   end

endmodule

// File: tb/tb_mac_sequencer.sv
// Scoreboard bench for mac_sequencer with a behavioural multiplier responder
// and a dot-product reference model.
module tb_mac_sequencer;

   localparam int W       = 4;
   localparam int N_TERMS = 4;
   localparam int ACC_W   = 10;
   localparam int TIMEOUT = 32;
   localparam int BUDGET  = 400;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [W-1:0]     in_a = '0;
   logic [W-1:0]     in_b = '0;
   logic             mul_start;
   logic [W-1:0]     mul_a;
   logic [W-1:0]     mul_b;
   logic [2*W-1:0]   mul_p = '0;
   logic             mul_done = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [ACC_W-1:0] out_sum;
   logic             err;

   always #5 clk = ~clk;

   mac_sequencer #(.W(W), .N_TERMS(N_TERMS), .ACC_W(ACC_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
      .mul_p(mul_p), .mul_done(mul_done),
      .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
      .err(err)
   );

   int               n_checks = 0;
   int               n_fail = 0;
   logic [2*W-1:0]   opq[$];
   int               expq[$];
   int               partial = 0;
   int               nterm = 0;
   int               n_starts = 0;
   bit               stub = 1'b0;
   bit               rand_ready = 1'b0;
   bit               holding = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference model: a batch result is the plain sum of products modulo 2^ACC_W.
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
      int t;
      t = 0;
      in_valid = 1'b1;
      in_a = a;
      in_b = b;
      while (!in_ready && t < BUDGET) begin
         @(negedge clk);
         t++;
      end
      check("accept_wait", t < BUDGET, 1);
      opq.push_back({a, b});
      partial += int'(a) * int'(b);
      nterm++;
      if (nterm == N_TERMS) begin
         expq.push_back(partial % (1 << ACC_W));
         partial = 0;
         nterm = 0;
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic drain_all();
      int t;
      t = 0;
      while ((expq.size() != 0 || holding) && t < BUDGET) begin
         @(negedge clk);
         t++;
      end
      check("drain_queue_empty", expq.size(), 0);
      repeat (3) @(negedge clk);
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while (!in_ready && t < BUDGET) begin
         @(negedge clk);
         t++;
      end
      check("idle_wait", in_ready, 1);
   endtask

   // Multiplier responder: variable latency, done sometimes held two cycles,
   // occasional stray done pulses while no multiply is pending.
   initial begin
      int cnt;
      int hold;
      bit busy;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      cnt = 0; hold = 0; busy = 1'b0; ra = '0; rb = '0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            busy = 1'b0;
            hold = 0;
            mul_done = 1'b0;
         end else begin
            if (hold > 0) hold--;
            if (hold == 0) mul_done = 1'b0;
            if (busy) begin
               cnt--;
               if (cnt == 0) begin
                  busy = 1'b0;
                  check("mul_a_stable", mul_a, ra);
                  check("mul_b_stable", mul_b, rb);
                  mul_p = ra * rb;
                  mul_done = 1'b1;
                  hold = $urandom_range(1, 2);
               end
            end else if (mul_start && !stub) begin
               busy = 1'b1;
               ra = mul_a;
               rb = mul_b;
               cnt = $urandom_range(1, 5);
               if ($urandom_range(0, 3) == 0) begin
                  mul_p = '1;
                  mul_done = 1'b1;
                  hold = 1;
               end
            end else if (!stub && hold == 0 && $urandom_range(0, 7) == 0) begin
               mul_p = (2*W)'($urandom);
               mul_done = 1'b1;
               hold = 1;
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (rand_ready) out_ready = ($urandom_range(0, 2) != 0);
      end
   end

   // Monitor: samples after all negedge-driven stimulus has settled.
   initial begin
      int cur;
      bit prev_start;
      bit xfer;
      logic [2*W-1:0] o;
      cur = -1; prev_start = 1'b0; xfer = 1'b0; o = '0;
      forever begin
         @(negedge clk);
         #2;
         if (!rst) begin
            holding = 1'b0;
            prev_start = 1'b0;
            xfer = 1'b0;
         end else begin
            if (mul_start) begin
               n_starts++;
               check("start_width", prev_start, 0);
               check("start_pending", opq.size() > 0, 1);
               if (opq.size() > 0) begin
                  o = opq.pop_front();
                  check("mul_a", mul_a, o[2*W-1:W]);
                  check("mul_b", mul_b, o[W-1:0]);
               end
            end
            prev_start = mul_start;
            if (xfer) check("out_valid_drop", out_valid, 0);
            xfer = 1'b0;
            if (out_valid) begin
               if (!holding) begin
                  check("out_pending", expq.size() > 0, 1);
                  cur = (expq.size() > 0) ? expq.pop_front() : -1;
                  holding = 1'b1;
               end
               check("out_sum", out_sum, cur);
               check("in_ready_in_out", in_ready, 0);
               if (out_ready) begin
                  holding = 1'b0;
                  xfer = 1'b1;
               end
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int s0;
      int t;
      logic [W-1:0] ta[4];
      logic [W-1:0] tb[4];
      ta = '{4'd6, 4'd2, 4'd15, 4'd1};
      tb = '{4'd3, 4'd5, 4'd15, 4'd0};

      repeat (2) @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_mul_start", mul_start, 0);
      check("rst_err", err, 0);
      check("rst_out_sum", out_sum, 0);
      check("rst_mul_a", mul_a, 0);
      check("rst_mul_b", mul_b, 0);
      rst = 1'b1;
      @(negedge clk);
      check("rst_in_ready", in_ready, 1);

      // basic dot product
      s0 = n_starts;
      for (int i = 0; i < 4; i++) send(ta[i], tb[i]);
      drain_all();
      check("basic_starts", n_starts - s0, 4);
      check("basic_err", err, 0);

      // backpressure
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) send(ta[i], tb[i]);
      t = 0;
      while (!out_valid && t < BUDGET) begin
         @(negedge clk);
         t++;
      end
      check("bp_valid_seen", out_valid, 1);
      for (int i = 0; i < 10; i++) begin
         check("bp_sum_hold", out_sum, 253);
         check("bp_in_ready", in_ready, 0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_valid_clear", out_valid, 0);
      check("bp_in_ready_back", in_ready, 1);
      drain_all();

      // back-to-back batches of maximum products
      for (int i = 0; i < 8; i++) send(4'd15, 4'd15);
      drain_all();

      // input gaps
      s0 = n_starts;
      for (int i = 0; i < 4; i++) begin
         send(4'd1, 4'd1);
         repeat (5) @(negedge clk);
      end
      drain_all();
      check("gap_starts", n_starts - s0, 4);

      // randomized traffic with random consumer backpressure
      rand_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         send(W'($urandom), W'($urandom));
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      rand_ready = 1'b0;
      @(negedge clk);
      out_ready = 1'b1;
      drain_all();

      // timeout: WAIT occupies TIMEOUT cycles, err visible on the cycle after
      check("err_pre_timeout", err, 0);
      stub = 1'b1;
      send(4'd3, 4'd3);
      check("to_start", mul_start, 1);
      for (int k = 1; k <= TIMEOUT + 1; k++) begin
         @(negedge clk);
         if (k == TIMEOUT) check("to_err_early", err, 0);
      end
      check("to_err_set", err, 1);
      check("to_in_ready", in_ready, 1);
      check("to_no_out", out_valid, 0);
      partial = 0;
      nterm = 0;
      stub = 1'b0;
      for (int i = 0; i < 4; i++) send(4'd1, 4'd1);
      drain_all();
      check("to_err_sticky", err, 1);

      // reset while waiting on the second term
      send(4'd2, 4'd2);
      wait_idle();
      stub = 1'b1;
      send(4'd2, 4'd2);
      @(negedge clk);
      check("mid_in_wait", in_ready, 0);
      rst = 1'b0;
      opq.delete();
      expq.delete();
      partial = 0;
      nterm = 0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      stub = 1'b0;
      check("mid_in_ready", in_ready, 1);
      check("mid_out_valid", out_valid, 0);
      check("mid_mul_start", mul_start, 0);
      check("mid_err", err, 0);
      @(negedge clk);
      for (int i = 0; i < 4; i++) send(4'd2, 4'd2);
      drain_all();
      check("final_opq_empty", opq.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
